// File: rtl/ecc_csr_pkg.sv
// ecc_csr_pkg: FSM states, CSR address helpers and byte-lane merge for ecc_csr_bank
package ecc_csr_pkg;
  localparam int MAX_W = 256;
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;
  function automatic int start_addr(input int aw);
    return (1 << aw) - 2;
  endfunction
  function automatic int done_addr(input int aw);
    return (1 << aw) - 1;
  endfunction
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W/8-1:0] be);
    byte_merge = old_w;
    for (int i = 0; i < MAX_W / 8; i++)
      if (be[i]) byte_merge[i*8 +: 8] = new_w[i*8 +: 8];
  endfunction
endpackage

// File: rtl/csr_word_reg.sv
// csr_word_reg: one byte-writable CSR word with a priority full-word parallel load
module csr_word_reg
  import ecc_csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] data_q, data_d;
  always_comb data_d = ld ? ld_data : we ? DATA_W'(byte_merge(MAX_W'(data_q), MAX_W'(wdata), (MAX_W/8)'(be))) : data_q;
  always_ff @(posedge clk) data_q <= rst ? '0 : data_d;
  assign q = data_q;
endmodule

// File: rtl/ecc_csr_bank.sv
// ecc_csr_bank: Avalon-MM CSR bank for an ECC core (optional irq output via ECC_CSR_IRQ_EN)
module ecc_csr_bank
  import ecc_csr_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MSG_WORDS = 8,
  parameter int KEY_WORDS = 8,
  parameter int ADDR_W    = 5
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        AVL_CS,
  input  logic                        AVL_READ,
  input  logic                        AVL_WRITE,
  input  logic [ADDR_W-1:0]           AVL_ADDR,
  input  logic [DATA_W/8-1:0]         AVL_BYTE_EN,
  input  logic [DATA_W-1:0]           AVL_WRITEDATA,
  output logic [DATA_W-1:0]           AVL_READDATA,
  output logic [MSG_WORDS*DATA_W-1:0] msg_out,
  output logic                        start_o,
  input  logic                        core_done_i,
  input  logic [KEY_WORDS*DATA_W-1:0] key_in
`ifdef ECC_CSR_IRQ_EN
  ,output logic                       irq
`endif
);
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(start_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] DONE_A  = ADDR_W'(done_addr(ADDR_W));
  state_t state_q, state_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_word, start_rd;
  logic [DATA_W-1:0] msg_w [MSG_WORDS];
  logic [DATA_W-1:0] key_w [KEY_WORDS];
  logic wr, rd, busy, capture, start_wr, done_clr;
  assign wr       = AVL_CS & AVL_WRITE;
  assign rd       = AVL_CS & AVL_READ;
  assign busy     = (state_q == S_START) || (state_q == S_BUSY);
  assign capture  = (state_q == S_BUSY) && core_done_i;
  assign start_wr = wr && AVL_ADDR == START_A && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign done_clr = wr && AVL_ADDR == DONE_A && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign start_o  = state_q == S_START;
  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
    csr_word_reg #(.DATA_W(DATA_W)) u_reg (
      .clk(Clk), .rst(Reset), .we(wr && !busy && AVL_ADDR == ADDR_W'(g)), .be(AVL_BYTE_EN),
      .wdata(AVL_WRITEDATA), .ld(1'b0), .ld_data('0), .q(msg_w[g])
    );
    assign msg_out[g*DATA_W +: DATA_W] = msg_w[g];
  end
  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    csr_word_reg #(.DATA_W(DATA_W)) u_reg (
      .clk(Clk), .rst(Reset), .we(1'b0), .be('0), .wdata('0),
      .ld(capture), .ld_data(key_in[g*DATA_W +: DATA_W]), .q(key_w[g])
    );
  end
`ifdef ECC_CSR_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  always_comb begin
    irq_en_d = (wr && AVL_ADDR == START_A && AVL_BYTE_EN[0]) ? AVL_WRITEDATA[1] : irq_en_q;
    irq_d    = done_q & irq_en_q;
  end
  always_ff @(posedge Clk) begin
    irq_en_q <= Reset ? 1'b0 : irq_en_d;
    irq_q    <= Reset ? 1'b0 : irq_d;
  end
  assign irq      = irq_q;
  assign start_rd = DATA_W'({irq_en_q, busy});
`else
  assign start_rd = DATA_W'(busy);
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_wr ? S_START : S_IDLE;
      S_START: state_d = S_BUSY;
      S_BUSY:  state_d = capture ? S_DONE : S_BUSY;
      S_DONE:  state_d = start_wr ? S_START : done_clr ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
    done_d = capture ? 1'b1 : (state_q == S_DONE && (start_wr || done_clr)) ? 1'b0 : done_q;
  end
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MSG_WORDS; i++)
      if (AVL_ADDR == ADDR_W'(i)) rd_word = msg_w[i];
    for (int i = 0; i < KEY_WORDS; i++)
      if (AVL_ADDR == ADDR_W'(MSG_WORDS + i)) rd_word = key_w[i];
    if (AVL_ADDR == START_A) rd_word = start_rd;
    if (AVL_ADDR == DONE_A) rd_word = DATA_W'(done_q);
    rdata_d = rd ? rd_word : rdata_q;
  end
  always_ff @(posedge Clk) begin
    state_q <= Reset ? S_IDLE : state_d;
    done_q  <= Reset ? 1'b0 : done_d;
    rdata_q <= Reset ? '0 : rdata_d;
  end
  assign AVL_READDATA = rdata_q;
endmodule
